// File: rtl/conf_ctrl_if.sv
// Bundle between the button front end, the target registers and the screen driver
// and the time/alarm configuration controller.
interface conf_ctrl_if #(
    parameter int unsigned NUM_FIELDS = 3,
    parameter int unsigned NUM_CH     = 2
);
    localparam int unsigned CH_W    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int unsigned FIELD_W = $clog2(NUM_FIELDS) + 1;
    localparam int unsigned DATA_W  = NUM_FIELDS * 8;

    logic              set_btn;
    logic              inc_btn;
    logic              dec_btn;
    logic [CH_W-1:0]   ch_sel;
    logic [DATA_W-1:0] cur_val;

    logic               busy;
    logic [FIELD_W-1:0] edit_field;
    logic [DATA_W-1:0]  disp_data;
    logic               disp_pulse;
    logic               commit_valid;
    logic [CH_W-1:0]    commit_ch;
    logic [DATA_W-1:0]  commit_data;
    logic               abort_pulse;

    // Front end / environment side.
    modport master (
        output set_btn, inc_btn, dec_btn, ch_sel, cur_val,
        input  busy, edit_field, disp_data, disp_pulse,
        input  commit_valid, commit_ch, commit_data, abort_pulse
    );

    // Controller side.
    modport slave (
        input  set_btn, inc_btn, dec_btn, ch_sel, cur_val,
        output busy, edit_field, disp_data, disp_pulse,
        output commit_valid, commit_ch, commit_data, abort_pulse
    );
endinterface

// File: rtl/conf_ctrl.sv
// BCD time/alarm configuration controller: walk fields with set, edit with inc/dec,
// commit or abort on timeout. Optional hold-to-repeat enabled by CONF_AUTO_REPEAT_EN.
module conf_ctrl #(
    parameter int unsigned NUM_FIELDS    = 3,
    parameter int unsigned NUM_CH        = 2,
    parameter logic [7:0]  LOW_MAX       = 8'h59,
    parameter logic [7:0]  TOP_MAX       = 8'h23,
    parameter int unsigned TIMEOUT_CYC   = 1000,
    parameter int unsigned REPEAT_DELAY  = 500,
    parameter int unsigned REPEAT_PERIOD = 100
) (
    input logic         clk,
    input logic         rst,
    conf_ctrl_if.slave  bus
);
    localparam int unsigned CH_W    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
    localparam int unsigned FIELD_W = $clog2(NUM_FIELDS) + 1;
    localparam int unsigned DATA_W  = NUM_FIELDS * 8;
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [FIELD_W-1:0] LAST_FIELD = FIELD_W'(NUM_FIELDS - 1);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic {StIdle, StEdit} state_e;

    state_e             state_q;
    logic               set_q, set_qq, inc_q, inc_qq, dec_q, dec_qq;
    logic [DATA_W-1:0]  buf_q;
    logic [FIELD_W-1:0] field_q;
    logic [CH_W-1:0]    ch_q;
    logic [TO_W-1:0]    cnt_q;
    logic               busy_q, disp_pulse_q, commit_valid_q, abort_q;
    logic [CH_W-1:0]    commit_ch_q;
    logic [DATA_W-1:0]  commit_data_q;

    logic              set_ev, inc_ev, dec_ev, step_up, step_dn;
    logic [7:0]        sel_val, sel_max, new_val;
    logic [DATA_W-1:0] buf_step;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] m);
        if (v >= m) return 8'h00;
        if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
        return v + 8'h01;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] m);
        if (v == 8'h00 || v > m) return m;
        if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
        return v - 8'h01;
    endfunction

    assign set_ev = set_q & ~set_qq;
    assign inc_ev = inc_q & ~inc_qq;
    assign dec_ev = dec_q & ~dec_qq;

`ifdef CONF_AUTO_REPEAT_EN
    logic [31:0] rpt_cnt_q;
    logic        rpt_on_q;
    logic        held_inc, held_dec, rpt_fire;

    assign held_inc = inc_q & inc_qq & ~dec_q;
    assign held_dec = dec_q & dec_qq & ~inc_q;
    assign rpt_fire = rpt_on_q & (held_inc | held_dec) & ~set_ev & (rpt_cnt_q == 32'd1);
    assign step_up  = ~set_ev & ((inc_ev & ~dec_ev) | (rpt_fire & held_inc));
    assign step_dn  = ~set_ev & ((dec_ev & ~inc_ev) | (rpt_fire & held_dec));
`else
    assign step_up  = ~set_ev & inc_ev & ~dec_ev;
    assign step_dn  = ~set_ev & dec_ev & ~inc_ev;
`endif

    always_comb begin
        sel_val = 8'h00;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (field_q == FIELD_W'(f)) sel_val = buf_q[f*8 +: 8];
        end
        sel_max  = (field_q == LAST_FIELD) ? TOP_MAX : LOW_MAX;
        new_val  = step_up ? bcd_inc(sel_val, sel_max) : bcd_dec(sel_val, sel_max);
        buf_step = buf_q;
        for (int f = 0; f < NUM_FIELDS; f++) begin
            if (field_q == FIELD_W'(f)) buf_step[f*8 +: 8] = new_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            set_q          <= 1'b0;
            set_qq         <= 1'b0;
            inc_q          <= 1'b0;
            inc_qq         <= 1'b0;
            dec_q          <= 1'b0;
            dec_qq         <= 1'b0;
            buf_q          <= '0;
            field_q        <= '0;
            ch_q           <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            disp_pulse_q   <= 1'b0;
            commit_valid_q <= 1'b0;
            commit_ch_q    <= '0;
            commit_data_q  <= '0;
            abort_q        <= 1'b0;
`ifdef CONF_AUTO_REPEAT_EN
            rpt_cnt_q      <= '0;
            rpt_on_q       <= 1'b0;
`endif
        end else begin
            set_q          <= bus.set_btn;
            set_qq         <= set_q;
            inc_q          <= bus.inc_btn;
            inc_qq         <= inc_q;
            dec_q          <= bus.dec_btn;
            dec_qq         <= dec_q;
            disp_pulse_q   <= 1'b0;
            commit_valid_q <= 1'b0;
            abort_q        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (set_ev) begin
                        buf_q        <= bus.cur_val;
                        ch_q         <= bus.ch_sel;
                        field_q      <= '0;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        disp_pulse_q <= 1'b1;
                        state_q      <= StEdit;
                    end
                end
                StEdit: begin
                    if (set_ev) begin
                        cnt_q        <= '0;
                        disp_pulse_q <= 1'b1;
                        if (field_q == LAST_FIELD) begin
                            commit_valid_q <= 1'b1;
                            commit_ch_q    <= ch_q;
                            commit_data_q  <= buf_q;
                            busy_q         <= 1'b0;
                            field_q        <= '0;
                            state_q        <= StIdle;
                        end else begin
                            field_q <= field_q + 1'b1;
                        end
                    end else if (step_up || step_dn) begin
                        buf_q        <= buf_step;
                        disp_pulse_q <= 1'b1;
                        cnt_q        <= '0;
                    end else if (inc_ev || dec_ev) begin
                        cnt_q <= '0;
                    end else if (cnt_q == TO_LAST) begin
                        // Buffer is kept so the screen still shows the abandoned edit.
                        abort_q      <= 1'b1;
                        busy_q       <= 1'b0;
                        field_q      <= '0;
                        disp_pulse_q <= (field_q != '0);
                        state_q      <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`ifdef CONF_AUTO_REPEAT_EN
                    if (set_ev || (inc_q && dec_q)) begin
                        rpt_on_q <= 1'b0;
                    end else if ((inc_ev && !dec_ev) || (dec_ev && !inc_ev)) begin
                        rpt_on_q  <= 1'b1;
                        rpt_cnt_q <= REPEAT_DELAY;
                    end else if (rpt_on_q && (held_inc || held_dec)) begin
                        rpt_cnt_q <= (rpt_cnt_q == 32'd1) ? REPEAT_PERIOD : rpt_cnt_q - 32'd1;
                    end else begin
                        rpt_on_q <= 1'b0;
                    end
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.edit_field   = field_q;
    assign bus.disp_data    = buf_q;
    assign bus.disp_pulse   = disp_pulse_q;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_ch    = commit_ch_q;
    assign bus.commit_data  = commit_data_q;
    assign bus.abort_pulse  = abort_q;
endmodule

// File: tb/tb_conf_ctrl.sv
// Self-checking bench for conf_ctrl: table of button vectors with a scoreboard queue,
// plus hand-written commit, timeout, reset and hold sequences.
module tb_conf_ctrl;
    localparam int unsigned TO = 20;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conf_ctrl_if #(.NUM_FIELDS(3), .NUM_CH(2)) bus ();

    conf_ctrl #(
        .NUM_FIELDS(3), .NUM_CH(2), .LOW_MAX(8'h59), .TOP_MAX(8'h23),
        .TIMEOUT_CYC(TO), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        s, i, d;
        logic        pulse;
        logic [23:0] data;
        logic [2:0]  field;
    } vec_t;

    typedef struct {
        logic [23:0] data;
        logic [2:0]  field;
        logic        busy;
    } exp_t;

    int   checks = 0;
    int   fails  = 0;
    exp_t sb_q[$];
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic i, input logic d);
        @(posedge clk);
        #1;
        bus.set_btn = s;
        bus.inc_btn = i;
        bus.dec_btn = d;
    endtask

    // Press for one cycle, then wait for the display pulse and score against the queue.
    task automatic apply(input string tag, input vec_t v);
        int   lat;
        exp_t e;
        drive(v.s, v.i, v.d);
        e.data  = v.data;
        e.field = v.field;
        e.busy  = 1'b1;
        sb_q.push_back(e);
        drive(1'b0, 1'b0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.disp_pulse) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, lat, v.pulse ? 2 : 0);
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " data"}, {8'h0, bus.disp_data}, {8'h0, e.data});
            chk({tag, " field"}, {29'h0, bus.edit_field}, {29'h0, e.field});
            chk({tag, " busy"}, {31'h0, bus.busy}, {31'h0, e.busy});
        end
        if (v.pulse) begin
            @(negedge clk);
            chk({tag, " pulse width"}, {31'h0, bus.disp_pulse}, 32'h0);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic i, input logic d, input logic p,
                                input logic [23:0] data, input logic [2:0] field);
        vec_t v;
        v.s = s; v.i = i; v.d = d; v.pulse = p; v.data = data; v.field = field;
        return v;
    endfunction

    task automatic do_commit(input string tag, input logic [23:0] exp_data, input logic exp_ch);
        int lat;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.commit_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, " commit latency"}, lat, 2);
        chk({tag, " commit_ch"}, {31'h0, bus.commit_ch}, {31'h0, exp_ch});
        chk({tag, " commit_data"}, {8'h0, bus.commit_data}, {8'h0, exp_data});
        chk({tag, " busy after commit"}, {31'h0, bus.busy}, 32'h0);
        chk({tag, " field after commit"}, {29'h0, bus.edit_field}, 32'h0);
        @(negedge clk);
        chk({tag, " commit width"}, {31'h0, bus.commit_valid}, 32'h0);
    endtask

    initial begin
        int   n_abort;
        logic seen_commit, seen_any;

        vecs[0]  = mk(1, 0, 0, 1, 24'h235958, 3'd0);
        vecs[1]  = mk(0, 1, 0, 1, 24'h235959, 3'd0);
        vecs[2]  = mk(0, 1, 0, 1, 24'h235900, 3'd0);
        vecs[3]  = mk(0, 0, 1, 1, 24'h235959, 3'd0);
        vecs[4]  = mk(0, 1, 1, 0, 24'h235959, 3'd0);
        vecs[5]  = mk(1, 1, 0, 1, 24'h235959, 3'd1);
        vecs[6]  = mk(0, 1, 0, 1, 24'h230059, 3'd1);
        vecs[7]  = mk(0, 0, 1, 1, 24'h235959, 3'd1);
        vecs[8]  = mk(1, 0, 0, 1, 24'h235959, 3'd2);
        vecs[9]  = mk(0, 1, 0, 1, 24'h005959, 3'd2);
        vecs[10] = mk(0, 0, 1, 1, 24'h235959, 3'd2);

        rst = 1'b1;
        bus.set_btn = 1'b0;
        bus.inc_btn = 1'b0;
        bus.dec_btn = 1'b0;
        bus.ch_sel  = 1'b0;
        bus.cur_val = 24'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset busy", {31'h0, bus.busy}, 32'h0);
        chk("reset field", {29'h0, bus.edit_field}, 32'h0);
        chk("reset disp_data", {8'h0, bus.disp_data}, 32'h0);
        chk("reset pulses", {29'h0, bus.disp_pulse, bus.commit_valid, bus.abort_pulse}, 32'h0);

        // Session 1: channel 1, walk all fields and commit.
        bus.cur_val = 24'h235958;
        bus.ch_sel  = 1'b1;
        for (int n = 0; n < 11; n++) apply($sformatf("vec%0d", n), vecs[n]);
        do_commit("s1", 24'h235959, 1'b1);

        // Session 2: decrement with borrow in the top field; inputs ignored mid-edit.
        bus.cur_val = 24'h100000;
        bus.ch_sel  = 1'b0;
        apply("s2 enter", mk(1, 0, 0, 1, 24'h100000, 3'd0));
        bus.cur_val = 24'h777777;
        bus.ch_sel  = 1'b1;
        apply("s2 f1", mk(1, 0, 0, 1, 24'h100000, 3'd1));
        apply("s2 f2", mk(1, 0, 0, 1, 24'h100000, 3'd2));
        apply("s2 dec", mk(0, 0, 1, 1, 24'h090000, 3'd2));
        do_commit("s2", 24'h090000, 1'b0);

        // Timeout abort.
        bus.cur_val = 24'h123456;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        seen_any = 1'b0;
        for (int k = 0; k < 6 && !seen_any; k++) begin
            @(negedge clk);
            seen_any = bus.disp_pulse;
        end
        chk("to entry", {31'h0, seen_any}, 32'h1);
        n_abort = 0;
        seen_commit = 1'b0;
        for (int k = 1; k <= int'(TO) + 4; k++) begin
            @(negedge clk);
            if (bus.commit_valid) seen_commit = 1'b1;
            if (bus.abort_pulse) begin
                n_abort = k;
                break;
            end
        end
        chk("to abort cycle", n_abort, TO);
        chk("to busy", {31'h0, bus.busy}, 32'h0);
        chk("to disp kept", {8'h0, bus.disp_data}, 32'h123456);
        @(negedge clk);
        chk("to abort width", {31'h0, bus.abort_pulse}, 32'h0);
        chk("to no commit", {31'h0, seen_commit}, 32'h0);

        // Reset in the middle of an edit.
        apply("rst enter", mk(1, 0, 0, 1, 24'h123456, 3'd0));
        apply("rst inc", mk(0, 1, 0, 1, 24'h123457, 3'd0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen_any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.busy || bus.disp_pulse || bus.commit_valid || bus.abort_pulse ||
                bus.edit_field != 3'd0 || bus.disp_data != 24'h0) seen_any = 1'b1;
        end
        chk("rst mid-edit quiet", {31'h0, seen_any}, 32'h0);

        // Hold inc for 10 cycles from 00.
        bus.cur_val = 24'h000000;
        apply("hold enter", mk(1, 0, 0, 1, 24'h000000, 3'd0));
        drive(1'b0, 1'b1, 1'b0);
        repeat (9) @(posedge clk);
        drive(1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
`ifdef CONF_AUTO_REPEAT_EN
        chk("hold repeat", {8'h0, bus.disp_data}, 32'h000004);
`else
        chk("hold single", {8'h0, bus.disp_data}, 32'h000001);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
